// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default widths for the seconds timer
package timer_pkg;
  typedef enum logic [1:0] {T_IDLE, T_RUN, T_PAUSE, T_EXPIRED} timer_state_t;
  localparam int TIMER_CNT_W_DEF = 8;
endpackage

// File: rtl/tick_edge_det.sv
// tick_edge_det: two-flop sampler of the divider clkout producing one-cycle ticks
module tick_edge_det #(
  parameter bit BOTH_EDGES = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic din,
  output logic tick
);
  logic r_s1, r_s2;
  // clearing while the divider is held keeps a stale level from firing on resume
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end
  assign tick = BOTH_EDGES ? (r_s1 ^ r_s2) : (r_s1 & ~r_s2);
endmodule

// File: rtl/seconds_timer_ctrl.sv
// seconds_timer_ctrl: countdown controller sequencing the 1 s divider and counting seconds to zero
module seconds_timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W           = TIMER_CNT_W_DEF,
  parameter bit TICK_BOTH_EDGES = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clkout,
  output logic             div_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             paused,
  output logic             expired,
  output logic             done
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  timer_state_t     r_state, w_next;
  logic [CNT_W-1:0] r_rem, w_rem;
  logic             r_div_reset, r_busy, r_paused, r_expired, r_done, w_done, w_tick;
  tick_edge_det #(.BOTH_EDGES(TICK_BOTH_EDGES)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (r_div_reset),
    .din  (div_clkout),
    .tick (w_tick)
  );
  always_comb begin
    w_next = r_state;
    w_rem  = r_rem;
    w_done = 1'b0;
    if (clear) begin
      w_next = T_IDLE;
      w_rem  = '0;
    end else begin
      case (r_state)
        T_IDLE: begin
          if (load) w_rem = load_val;
          else if (start && r_rem != '0) w_next = T_RUN;
        end
        T_RUN: begin
          if (w_tick && r_rem != '0) w_rem = r_rem - ONE;
          if (w_tick && r_rem == ONE) begin
            w_next = T_EXPIRED;
            w_done = 1'b1;
          end else if (pause) w_next = T_PAUSE;
        end
        T_PAUSE: begin
          if (load) w_rem = load_val;
          else if (start && r_rem != '0) w_next = T_RUN;
        end
        T_EXPIRED: begin
          if (load) begin
            w_rem  = load_val;
            w_next = T_IDLE;
          end else if (start && r_rem != '0) w_next = T_RUN;
        end
        default: w_next = T_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= T_IDLE;
      r_rem       <= '0;
      r_div_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_paused    <= 1'b0;
      r_expired   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rem       <= w_rem;
      r_div_reset <= (w_next != T_RUN);
      r_busy      <= (w_next == T_RUN);
      r_paused    <= (w_next == T_PAUSE);
      r_expired   <= (w_next == T_EXPIRED);
      r_done      <= w_done;
    end
  end
  assign remaining = r_rem;
  assign div_reset = r_div_reset;
  assign busy      = r_busy;
  assign paused    = r_paused;
  assign expired   = r_expired;
  assign done      = r_done;
endmodule

// File: tb/tb_seconds_timer_ctrl.sv
// tb_seconds_timer_ctrl: table-driven directed bench for the countdown controller
module tb_seconds_timer_ctrl;
  logic       clk = 1'b0, reset = 1'b1, div_clkout = 1'b0, div_reset;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [7:0] load_val = '0, remaining;
  logic       busy, paused, expired, done;
  int         total = 0, bad = 0;
  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st, pa, cl, ck;
    logic [7:0] rem;
    logic       bsy, pau, exp_, dn, dr;
  } vec_t;
  vec_t tbl[$];
  always #20 clk = ~clk;
  seconds_timer_ctrl dut (
    .clk(clk), .reset(reset), .div_clkout(div_clkout), .div_reset(div_reset),
    .load(load), .load_val(load_val), .start(start), .pause(pause), .clear(clear),
    .remaining(remaining), .busy(busy), .paused(paused), .expired(expired), .done(done)
  );
  function automatic vec_t mk(logic ld, logic [7:0] lv, logic st, logic pa, logic cl, logic ck,
                              logic [7:0] rem, logic bsy, logic pau, logic ex, logic dn, logic dr);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.cl = cl; v.ck = ck;
    v.rem = rem; v.bsy = bsy; v.pau = pau; v.exp_ = ex; v.dn = dn; v.dr = dr;
    return v;
  endfunction
  task automatic step(logic ld, logic [7:0] lv, logic st, logic pa, logic cl, logic ck);
    load = ld; load_val = lv; start = st; pause = pa; clear = cl; div_clkout = ck;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check(string name, logic [7:0] rem, logic bsy, logic pau, logic ex, logic dn, logic dr);
    logic [12:0] got, want;
    got  = {remaining, busy, paused, expired, done, div_reset};
    want = {rem, bsy, pau, ex, dn, dr};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: rem/busy/paused/expired/done/div_reset got %0d/%b%b%b%b%b want %0d/%b%b%b%b%b",
               name, got[12:5], got[4], got[3], got[2], got[1], got[0],
               want[12:5], want[4], want[3], want[2], want[1], want[0]);
    end
  endtask
  initial begin
    bit seen;
    tbl.push_back(mk(1,3,0,0,0,0, 3,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0, 3,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 3,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 3,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 2,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 2,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,1,0,1));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,1,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,2,0,0,0,0, 2,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0, 2,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 2,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,1, 2,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 2,0,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0, 2,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 2,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,5,0,0,0,0, 5,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0, 5,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 5,1,0,0,0,0));
    tbl.push_back(mk(1,9,0,0,0,1, 4,1,0,0,0,0));
    tbl.push_back(mk(1,9,0,0,0,1, 4,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 4,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 3,0,1,0,0,1));
    tbl.push_back(mk(1,7,0,0,0,0, 7,0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0, 1,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,0,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,1, 0,0,0,1,1,1));
    tbl.push_back(mk(1,2,0,0,0,0, 2,0,0,0,0,1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].pa, tbl[i].cl, tbl[i].ck);
      check($sformatf("vec%0d", i), tbl[i].rem, tbl[i].bsy, tbl[i].pau, tbl[i].exp_, tbl[i].dn, tbl[i].dr);
    end
    step(0, 0, 0, 0, 1, 0);
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("run_at_5", 5, 1, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    check("reset_mid_run", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      step(0, 0, 0, 0, 0, ((c / 5) % 2) == 1);
      seen = done;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: done got 0 want 1 within 60 cycles");
    end
    check("free_run_expired", 0, 0, 0, 1, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
